// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: drives the synchronous data RAM port, aligns and
// extends load data one cycle later, flags misaligned accesses, counts accesses.
module rv32i_mem_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_out,
  input  logic [31:0]      ex_rs2_data,
  input  logic             ex_we,
  input  logic             ex_re,
  input  logic [1:0]       ex_width,
  input  logic             ex_sign,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wbwe,
  output logic [31:0]      d_addr,
  output logic             d_we,
  output logic [3:0]       d_be,
  output logic [31:0]      d_wdata,
  input  logic [31:0]      d_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_wbwe,
  output logic [31:0]      wb_data,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] misalign_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;
  localparam logic [1:0]  W_BYTE = 2'b00;
  localparam logic [1:0]  W_HALF = 2'b01;
  localparam logic [1:0]  W_WORD = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [1:0]      bank;
    logic [1:0]      width;
    logic            sign;
    logic            load;
    logic [RD_W-1:0] rd;
    logic            wbwe;
    logic            misalign;
    logic [XLEN-1:0] alu;
  } m_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wbwe;
    logic            misalign;
    logic [XLEN-1:0] data;
  } wb_t;

  m_t  m_q, m_d;
  wb_t wb_q, wb_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] misalign_cnt_q, misalign_cnt_d;

  logic [1:0]      bank;
  logic            misalign;
  logic            accept;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;

  assign bank   = ex_alu_out[1:0];
  assign accept = ex_valid & ~stall;

  // Alignment check applies only to memory operations.
  always_comb begin
    misalign = 1'b0;
    if (ex_we || ex_re) begin
      case (ex_width)
        W_BYTE:  misalign = 1'b0;
        W_HALF:  misalign = bank[0];
        W_WORD:  misalign = |bank;
        default: misalign = 1'b1;
      endcase
    end
  end

  // RAM data port; during a stall the held M address is replayed so d_rdata stays put.
  always_comb begin
    d_addr  = stall ? m_q.addr : ex_alu_out;
    d_we    = accept & ex_we & ~misalign;
    d_wdata = ex_rs2_data << {bank, 3'b000};
    d_be    = 4'b0000;
    if (d_we) begin
      case (ex_width)
        W_BYTE:  d_be = 4'b0001 << bank;
        W_HALF:  d_be = 4'b0011 << bank;
        default: d_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    m_d = m_q;
    if (!stall) begin
      m_d.valid    = ex_valid;
      m_d.addr     = ex_alu_out;
      m_d.bank     = bank;
      m_d.width    = ex_width;
      m_d.sign     = ex_sign;
      m_d.load     = ex_valid & ex_re;
      m_d.rd       = ex_rd;
      m_d.wbwe     = ex_valid & ex_wbwe & ~misalign;
      m_d.misalign = ex_valid & misalign;
      m_d.alu      = ex_alu_out;
    end
  end

  // Lane-align the returned word and extend to the access width.
  always_comb begin
    ld_shift = d_rdata >> {m_q.bank, 3'b000};
    case (m_q.width)
      W_BYTE:  ld_ext = {{24{m_q.sign & ld_shift[7]}}, ld_shift[7:0]};
      W_HALF:  ld_ext = {{16{m_q.sign & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.valid    = m_q.valid;
      wb_d.rd       = m_q.rd;
      wb_d.wbwe     = m_q.wbwe;
      wb_d.misalign = m_q.misalign;
      if (m_q.load) begin
        wb_d.data = m_q.misalign ? '0 : ld_ext;
      end else begin
        wb_d.data = m_q.alu;
      end
    end
  end

  // Saturating per-type counters, advanced only on accepted operations.
  always_comb begin
    load_cnt_d     = load_cnt_q;
    store_cnt_d    = store_cnt_q;
    misalign_cnt_d = misalign_cnt_q;
    if (accept) begin
      if (ex_re && (load_cnt_q != CNT_MAX)) begin
        load_cnt_d = load_cnt_q + CNT_W'(1);
      end
      if (ex_we && !misalign && (store_cnt_q != CNT_MAX)) begin
        store_cnt_d = store_cnt_q + CNT_W'(1);
      end
      if (misalign && (misalign_cnt_q != CNT_MAX)) begin
        misalign_cnt_d = misalign_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q            <= '0;
      wb_q           <= '0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      misalign_cnt_q <= '0;
    end else begin
      m_q            <= m_d;
      wb_q           <= wb_d;
      load_cnt_q     <= load_cnt_d;
      store_cnt_q    <= store_cnt_d;
      misalign_cnt_q <= misalign_cnt_d;
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_rd        = wb_q.rd;
  assign wb_wbwe      = wb_q.wbwe;
  assign wb_data      = wb_q.data;
  assign wb_misalign  = wb_q.misalign;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign misalign_cnt = misalign_cnt_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: behavioural sync RAM, byte-level reference memory,
// scoreboard of writeback results checked with their pipeline latency.
module tb_rv32i_mem_stage;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             ex_valid;
  logic [31:0]      ex_alu_out;
  logic [31:0]      ex_rs2_data;
  logic             ex_we;
  logic             ex_re;
  logic [1:0]       ex_width;
  logic             ex_sign;
  logic [4:0]       ex_rd;
  logic             ex_wbwe;
  logic [31:0]      d_addr;
  logic             d_we;
  logic [3:0]       d_be;
  logic [31:0]      d_wdata;
  logic [31:0]      d_rdata;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_wbwe;
  logic [31:0]      wb_data;
  logic             wb_misalign;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] store_cnt;
  logic [CNT_W-1:0] misalign_cnt;

  rv32i_mem_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_alu_out   (ex_alu_out),
    .ex_rs2_data  (ex_rs2_data),
    .ex_we        (ex_we),
    .ex_re        (ex_re),
    .ex_width     (ex_width),
    .ex_sign      (ex_sign),
    .ex_rd        (ex_rd),
    .ex_wbwe      (ex_wbwe),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_be         (d_be),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_wbwe      (wb_wbwe),
    .wb_data      (wb_data),
    .wb_misalign  (wb_misalign),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt),
    .misalign_cnt (misalign_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wbwe;
    logic        mis;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          act      = 0;
  logic        last_adv = 1'b0;
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ram [0:255];
  logic [31:0] nw;
  int          exp_load, exp_store, exp_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    nw = ram[d_addr[9:2]];
    for (int j = 0; j < 4; j++) if (d_be[j]) nw[8*j +: 8] = d_wdata[8*j +: 8];
    if (d_we) ram[d_addr[9:2]] <= nw;
    d_rdata <= ram[d_addr[9:2]];
  end

  always @(posedge clk) if (!stall) act <= act + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) last_adv <= 1'b0;
    else       last_adv <= !stall;
  end

  // Compare each freshly captured WB bundle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && last_adv) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("wb_data", wb_data, e.data);
          check("wb_ctrl", 32'({wb_rd, wb_wbwe, wb_misalign}), 32'({e.rd, e.wbwe, e.mis}));
          check("wb_latency", 32'(act - e.t), 32'd2);
        end
      end else begin
        check("bubble_en", 32'({wb_wbwe, wb_misalign}), 32'd0);
      end
    end
  end

  task automatic check_cnts(input string tag);
    check({tag, "_load_cnt"}, 32'(load_cnt), 32'(exp_load));
    check({tag, "_store_cnt"}, 32'(store_cnt), 32'(exp_store));
    check({tag, "_mis_cnt"}, 32'(misalign_cnt), 32'(exp_mis));
  endtask

  task automatic do_op(input logic v, input logic we, input logic re, input logic [1:0] w,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic wbwe);
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdx, ld;
    int          sz, off;
    exp_t        e;
    mis = (we || re) && ((w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00));
    sz  = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    stall = 1'b0; ex_valid = v; ex_we = we; ex_re = re; ex_width = w; ex_sign = sg;
    ex_alu_out = a; ex_rs2_data = wd; ex_rd = rd; ex_wbwe = wbwe;
    #1;
    be = 4'b0000;
    wdx = 32'd0;
    if (v && we && !mis) for (int k = 0; k < sz; k++) be[off + k] = 1'b1;
    for (int j = 0; j < 4; j++) if (j >= off) wdx[8*j +: 8] = wd[8*(j - off) +: 8];
    check("d_we", 32'(d_we), 32'(v && we && !mis));
    check("d_be", 32'(d_be), 32'(be));
    check("d_addr", d_addr, a);
    if (v && we) check("d_wdata", d_wdata, wdx);
    if (v) begin
      if (re) begin
        ld = 32'd0;
        if (!mis) begin
          for (int k = 0; k < sz; k++) ld[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
          if (sg && sz < 4 && ld[8*sz - 1]) for (int b = 8*sz; b < 32; b++) ld[b] = 1'b1;
        end
      end else begin
        ld = a;
      end
      e.data = ld; e.rd = rd; e.wbwe = wbwe & ~mis; e.mis = mis; e.t = act;
      sb.push_back(e);
      if (re && exp_load < CMAX) exp_load++;
      if (we && !mis && exp_store < CMAX) exp_store++;
      if (mis && exp_mis < CMAX) exp_mis++;
      if (we && !mis) for (int k = 0; k < sz; k++) ref_mem[int'(a[9:0]) + k] = wd[8*k +: 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0; ex_we = 1'b0; ex_re = 1'b0; stall = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    exp_load = 0; exp_store = 0; exp_mis = 0;
    reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_alu_out = 32'd0; ex_rs2_data = 32'd0;
    ex_we = 1'b0; ex_re = 1'b0; ex_width = 2'b00; ex_sign = 1'b0; ex_rd = 5'd0; ex_wbwe = 1'b0;
    #1;
    check("rst_wb", 32'({wb_valid, wb_rd, wb_wbwe, wb_misalign}), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check_cnts("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Byte store then unsigned byte load.
    do_op(1, 1, 0, 2'b00, 0, 32'h0, 32'h80, 5'd0, 0);
    do_op(1, 0, 1, 2'b00, 0, 32'h0, 32'h0, 5'd1, 1);
    idle(2);

    // Word store, then byte/half/word loads out of it.
    do_op(1, 1, 0, 2'b10, 0, 32'h0, 32'h12345678, 5'd0, 0);
    do_op(1, 0, 1, 2'b00, 1, 32'h3, 32'h0, 5'd2, 1);
    do_op(1, 0, 1, 2'b01, 1, 32'h2, 32'h0, 5'd3, 1);
    do_op(1, 0, 1, 2'b10, 0, 32'h0, 32'h0, 5'd4, 1);
    idle(2);

    // Upper half store with negative value, signed and unsigned reloads.
    do_op(1, 1, 0, 2'b01, 0, 32'h2, 32'h0000FFFB, 5'd0, 0);
    do_op(1, 0, 1, 2'b01, 1, 32'h2, 32'h0, 5'd5, 1);
    do_op(1, 0, 1, 2'b01, 0, 32'h2, 32'h0, 5'd6, 1);
    idle(2);
    check_cnts("t3");

    // Misaligned store and load: no memory effect, flagged in WB.
    do_op(1, 1, 0, 2'b10, 0, 32'h1, 32'hDEADBEEF, 5'd8, 1);
    do_op(1, 0, 1, 2'b01, 1, 32'h3, 32'h0, 5'd9, 1);
    do_op(1, 0, 1, 2'b10, 0, 32'h0, 32'h0, 5'd10, 1);
    idle(2);
    check("t4_mis_cnt", 32'(misalign_cnt), 32'd2);
    check_cnts("t4");

    // Load held in M across a three-cycle stall.
    do_op(1, 1, 0, 2'b10, 0, 32'h4, 32'hCAFEF00D, 5'd0, 0);
    do_op(1, 1, 0, 2'b10, 0, 32'h40, 32'h11112222, 5'd0, 0);
    do_op(1, 0, 0, 2'b00, 0, 32'hA5A50001, 32'h0, 5'd7, 1);
    do_op(1, 0, 1, 2'b10, 0, 32'h4, 32'h0, 5'd11, 1);
    stall = 1'b1; ex_valid = 1'b1; ex_we = 1'b1; ex_re = 1'b0; ex_width = 2'b10;
    ex_alu_out = 32'h40; ex_rs2_data = 32'h33334444;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_d_addr", d_addr, 32'h4);
      check("stall_d_we", 32'({d_we, d_be}), 32'd0);
      check("stall_wb_data", wb_data, 32'hA5A50001);
      check("stall_wb_ctrl", 32'({wb_valid, wb_rd, wb_wbwe}), 32'({1'b1, 5'd7, 1'b1}));
      @(posedge clk); #1;
    end
    do_op(1, 1, 0, 2'b10, 0, 32'h40, 32'h33334444, 5'd0, 0);
    do_op(1, 0, 1, 2'b10, 0, 32'h40, 32'h0, 5'd12, 1);
    idle(3);
    check_cnts("t5");

    // Asynchronous reset with both levels occupied.
    do_op(1, 0, 1, 2'b00, 0, 32'h0, 32'h0, 5'd13, 1);
    do_op(1, 0, 0, 2'b00, 0, 32'h55, 32'h0, 5'd14, 1);
    ex_valid = 1'b0; ex_we = 1'b0; ex_re = 1'b0;
    #1 reset = 1'b1;
    sb.delete();
    exp_load = 0; exp_store = 0; exp_mis = 0;
    #1;
    check("arst_wb", 32'({wb_valid, wb_rd, wb_wbwe, wb_misalign}), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check_cnts("arst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // Load counter saturation.
    for (int i = 0; i < 17; i++) begin
      do_op(1, 0, 1, 2'b00, 1, 32'(i % 8), 32'h0, 5'(i), 1);
      if (i == 13) check_cnts("sat14");
    end
    idle(3);
    check("sat_load_cnt", 32'(load_cnt), 32'hF);
    check_cnts("sat");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
